// File: rtl/run_sequencer.sv
// Host-side sequencer: resets a processor core once, then starts and times
// NUM_PROGS programs back-to-back, reporting per-program RUN-cycle counts.
module run_sequencer #(
    parameter int unsigned NUM_PROGS = 3,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic        Abort,
    input  logic        Ack,
    output logic        CoreReset,
    output logic        CoreStart,
    output logic [1:0]  ProgSel,
    output logic        Busy,
    output logic [15:0] CycleCt,
    output logic        CycleValid,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        START,
        RUN,
        CAPT,
        ERR
    } state_t;

    localparam logic [1:0] LAST_PROG = 2'(NUM_PROGS - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic        ack_seen;
    logic        last_prog;
    logic        timeout_hit;

    // A halted core holds Ack high, so the first RUN cycle cannot end a program.
    assign ack_seen  = Ack && (count != '0);
    assign last_prog = (ProgSel == LAST_PROG);

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (Go) state_next = CRST;
            CRST:  state_next = START;
            START: state_next = RUN;
            RUN: begin
                if (ack_seen) begin
                    state_next = CAPT;
                end else if (count == TIMEOUT - 16'd1) begin
                    state_next  = ERR;
                    timeout_hit = !Abort;
                end
            end
            CAPT:    state_next = last_prog ? IDLE : START;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort reuses the ERR state only for its core-reset cycle; Err is not touched.
        if (Abort && (state != IDLE) && (state != ERR)) begin
            state_next = ERR;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            count      <= '0;
            ProgSel    <= '0;
            CycleCt    <= '0;
            Err        <= 1'b0;
            CoreReset  <= 1'b1;
            CoreStart  <= 1'b0;
            CycleValid <= 1'b0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_next;
            CoreReset  <= (state_next == CRST) || (state_next == ERR);
            CoreStart  <= (state_next == START);
            CycleValid <= (state_next == CAPT);
            Done       <= (state_next == CAPT) && last_prog;
            Busy       <= (state_next != IDLE);

            if (state == START) begin
                count <= '0;
            end else if ((state == RUN) && (count != '1)) begin
                count <= count + 16'd1;
            end

            if ((state == IDLE) && Go) begin
                ProgSel <= '0;
                Err     <= 1'b0;
            end else if ((state == CAPT) && (state_next == START)) begin
                ProgSel <= ProgSel + 2'd1;
            end

            if ((state == RUN) && (state_next == CAPT)) begin
                CycleCt <= count;
            end else if (timeout_hit) begin
                CycleCt <= '1;
                Err     <= 1'b1;
            end
        end
    end

endmodule
